// File: rtl/comparator_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_seq_pkg                                                   |
// | Shared types and defaults for the comparator operand sequencer.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package comparator_seq_pkg;

    localparam int c_default_timeout = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESULT = 2'd2,
        GAP    = 2'd3
    } seq_state_t;

    // Operands are held beside this struct because their width is per-instance.
    typedef struct packed {
        logic agb;
        logic aeb;
        logic alb;
        logic err;
        logic timeout;
    } cmp_result_t;

endpackage
`default_nettype wire

// File: rtl/comparator_operand_sequencer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fifo                                                         |
// | Power-of-two operand-pair buffer with show-ahead head output.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module operand_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (c_aw + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/comparator_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_operand_sequencer                                         |
// | Buffers operand pairs and drives one comparison at a time; optional  |
// | BUSY watchdog compiled in with SEQ_TIMEOUT_EN.                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module comparator_operand_sequencer
    import comparator_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = c_default_timeout
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  cmp_start,
    output logic [DATA_WIDTH-1:0] cmp_a,
    output logic [DATA_WIDTH-1:0] cmp_b,
    input  logic                  cmp_agb,
    input  logic                  cmp_aeb,
    input  logic                  cmp_alb,
    input  logic                  cmp_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  out_agb,
    output logic                  out_aeb,
    output logic                  out_alb,
    output logic                  out_err,
    output logic                  out_timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_t                  r_state;
    seq_state_t                  w_next;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [2*DATA_WIDTH-1:0]     w_head;
    logic                        w_pop;
    logic                        w_capture;
    logic                        w_timeout_hit;
    logic                        w_done_rise;
    logic                        r_done_q;
    logic [1:0]                  w_flag_sum;
    logic [DATA_WIDTH-1:0]       r_cmp_a;
    logic [DATA_WIDTH-1:0]       r_cmp_b;
    logic [DATA_WIDTH-1:0]       r_out_a;
    logic [DATA_WIDTH-1:0]       r_out_b;
    cmp_result_t                 r_res;

    assign in_ready = !w_fifo_full;

    operand_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_head)
    );

    assign w_done_rise = cmp_done && !r_done_q;
    assign w_flag_sum  = {1'b0, cmp_agb} + {1'b0, cmp_aeb} + {1'b0, cmp_alb};

`ifdef SEQ_TIMEOUT_EN
    localparam int                  c_wdog_w     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_wdog_w-1:0] c_wdog_limit = c_wdog_w'(TIMEOUT_CYCLES - 1);

    logic [c_wdog_w-1:0] r_wdog;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (w_pop) begin
            r_wdog <= '0;
        end else if (r_state == BUSY) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // A done edge arriving on the limit cycle takes priority over the abort.
    assign w_timeout_hit = (r_state == BUSY) && !w_done_rise && (r_wdog == c_wdog_limit);
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (w_done_rise) begin
                    w_capture = 1'b1;
                    w_next    = RESULT;
                end else if (w_timeout_hit) begin
                    w_next = RESULT;
                end
            end
            RESULT: if (out_ready) w_next = GAP;
            GAP:    if (!cmp_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q <= 1'b0;
            r_cmp_a  <= '0;
            r_cmp_b  <= '0;
            r_out_a  <= '0;
            r_out_b  <= '0;
            r_res    <= '0;
        end else begin
            r_done_q <= cmp_done;
            if (w_pop) begin
                r_cmp_a <= w_head[2*DATA_WIDTH-1:DATA_WIDTH];
                r_cmp_b <= w_head[DATA_WIDTH-1:0];
            end
            if (w_capture) begin
                r_out_a       <= r_cmp_a;
                r_out_b       <= r_cmp_b;
                r_res.agb     <= cmp_agb;
                r_res.aeb     <= cmp_aeb;
                r_res.alb     <= cmp_alb;
                r_res.err     <= (w_flag_sum != 2'd1);
                r_res.timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_out_a       <= r_cmp_a;
                r_out_b       <= r_cmp_b;
                r_res         <= '0;
                r_res.timeout <= 1'b1;
            end
        end
    end

    assign cmp_start   = (r_state == BUSY);
    assign cmp_a       = r_cmp_a;
    assign cmp_b       = r_cmp_b;
    assign out_valid   = (r_state == RESULT);
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_agb     = r_res.agb;
    assign out_aeb     = r_res.aeb;
    assign out_alb     = r_res.alb;
    assign out_err     = r_res.err;
    assign out_timeout = r_res.timeout;

endmodule
`default_nettype wire

// File: tb/tb_comparator_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_comparator_operand_sequencer                                      |
// | Directed bench with a behavioural comparator and result scoreboard.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_comparator_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_a = '0;
    logic [1:0] in_b = '0;
    logic       cmp_start;
    logic [1:0] cmp_a, cmp_b;
    logic       cmp_agb, cmp_aeb, cmp_alb, cmp_done;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_a, out_b;
    logic       out_agb, out_aeb, out_alb, out_err, out_timeout;

    int         total = 0;
    int         bad = 0;
    bit         bad_mode = 1'b0;
    bit         no_done = 1'b0;
    int         results_seen = 0;
    int         cmp_cnt;
    logic [8:0] model_q[$];
    logic [2:0] seen_flags[$];

    comparator_operand_sequencer #(
        .DATA_WIDTH     (2),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_a (in_a), .in_b (in_b),
        .cmp_start (cmp_start), .cmp_a (cmp_a), .cmp_b (cmp_b),
        .cmp_agb (cmp_agb), .cmp_aeb (cmp_aeb), .cmp_alb (cmp_alb), .cmp_done (cmp_done),
        .out_valid (out_valid), .out_ready (out_ready), .out_a (out_a), .out_b (out_b),
        .out_agb (out_agb), .out_aeb (out_aeb), .out_alb (out_alb),
        .out_err (out_err), .out_timeout (out_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result vector {a, b, agb, aeb, alb, err, timeout}
    function automatic logic [8:0] model_result(input logic [1:0] a, input logic [1:0] b,
                                                input bit bad_f, input bit to);
        int gt, eq, lt;
        if (to) return {a, b, 5'b00001};
        if (bad_f) begin
            gt = 1; eq = 1; lt = 0;
        end else begin
            gt = (a > b) ? 1 : 0;
            eq = (a == b) ? 1 : 0;
            lt = (a < b) ? 1 : 0;
        end
        return {a, b, gt[0], eq[0], lt[0], ((gt + eq + lt) != 1), 1'b0};
    endfunction

    // Behavioural comparator: done rises on the third clock that sees start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_cnt  <= 0;
            cmp_done <= 1'b0;
            cmp_agb  <= 1'b0;
            cmp_aeb  <= 1'b0;
            cmp_alb  <= 1'b0;
        end else if (cmp_start && !no_done) begin
            if (cmp_cnt == 2) begin
                cmp_done <= 1'b1;
                cmp_agb  <= bad_mode ? 1'b1 : (cmp_a > cmp_b);
                cmp_aeb  <= bad_mode ? 1'b1 : (cmp_a == cmp_b);
                cmp_alb  <= bad_mode ? 1'b0 : (cmp_a < cmp_b);
            end else begin
                cmp_cnt <= cmp_cnt + 1;
            end
        end else begin
            cmp_cnt  <= 0;
            cmp_done <= 1'b0;
        end
    end

    // Scoreboard: record accepted pairs, check every cycle a result is shown.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready)
                model_q.push_back(model_result(in_a, in_b, bad_mode, no_done));
            if (out_valid) begin
                if (model_q.size() == 0) begin
                    check("unexpected_result", {23'd0, out_a, out_b, out_agb, out_aeb, out_alb, out_err, out_timeout}, 32'hFFFF_FFFF);
                end else begin
                    check("result", {23'd0, out_a, out_b, out_agb, out_aeb, out_alb, out_err, out_timeout},
                          {23'd0, model_q[0]});
                    if (out_ready) begin
                        void'(model_q.pop_front());
                        seen_flags.push_back({out_agb, out_aeb, out_alb});
                        results_seen++;
                    end
                end
            end
        end
    end

    task automatic push(input logic [1:0] a, input logic [1:0] b, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) check("push_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!out_valid) check(name, 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (model_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(name, model_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, wsum, base, n;
        bit any;
        logic [2:0] exp4 [4];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {16'd0, in_ready, cmp_start, cmp_a, cmp_b, out_valid, out_a, out_b,
                                out_agb, out_aeb, out_alb, out_err, out_timeout}, 32'h0000_8000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single pair A=2, B=1
        push(2'd2, 2'd1, w);
        @(negedge clk);
        check("start_before_issue", cmp_start, 32'd0);
        @(negedge clk);
        check("start_issue", {cmp_start, cmp_a, cmp_b}, {27'd0, 1'b1, 2'd2, 2'd1});
        wait_valid("single_valid_timeout");
        check("single_literal", {out_a, out_b, out_agb, out_aeb, out_alb, out_err, out_timeout},
              {23'd0, 9'b10_01_100_0_0});
        check("start_low_in_result", cmp_start, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("single_drain");

        // Four pairs back-to-back with out_ready held high
        seen_flags.delete();
        wsum = 0;
        push(2'd0, 2'd0, w); wsum += w;
        push(2'd1, 2'd3, w); wsum += w;
        push(2'd3, 2'd1, w); wsum += w;
        push(2'd2, 2'd2, w); wsum += w;
        check("burst_in_ready_stayed_high", wsum, 32'd0);
        drain("burst_drain");
        exp4 = '{3'b010, 3'b001, 3'b100, 3'b010};
        check("burst_count", seen_flags.size(), 32'd4);
        for (int i = 0; i < 4 && i < seen_flags.size(); i++)
            check("burst_order", {29'd0, seen_flags[i]}, {29'd0, exp4[i]});

        // Fill: one in flight plus four buffered, sixth offer refused
        out_ready = 1'b0;
        base = results_seen;
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            push(2'(i), 2'(3 - i), w);
            wsum += w;
        end
        check("fill_no_stall", wsum, 32'd0);
        @(negedge clk);
        check("full_in_ready_low", in_ready, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sixth_refused", model_q.size(), 32'd5);
        out_ready = 1'b1;
        drain("fill_drain");
        check("fill_result_count", results_seen - base, 32'd5);

        // Non one-hot flags, result held for five cycles
        bad_mode = 1'b1;
        out_ready = 1'b0;
        push(2'd1, 2'd2, w);
        wait_valid("err_valid_timeout");
        check("err_literal", {out_a, out_b, out_agb, out_aeb, out_alb, out_err, out_timeout},
              {23'd0, 9'b01_10_110_1_0});
        repeat (5) @(negedge clk);
        check("err_held", {out_valid, out_a, out_b, out_agb, out_aeb, out_alb, out_err},
              {23'd0, 9'b1_01_10_110_1});
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("err_drain");
        bad_mode = 1'b0;

        // Asynchronous reset while BUSY with a pair still buffered
        push(2'd3, 2'd0, w);
        push(2'd1, 2'd1, w);
        n = 0;
        while (!cmp_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_busy", cmp_start, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_outputs", {cmp_start, out_valid, in_ready}, 32'd1);
        model_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cmp_start || out_valid) any = 1'b1;
        end
        check("rst_fifo_empty", {any, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Comparator never answers
        no_done = 1'b1;
        push(2'd1, 2'd1, w);
`ifdef SEQ_TIMEOUT_EN
        n = 0;
        while (!cmp_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 32'd8);
        check("timeout_literal", {out_a, out_b, out_agb, out_aeb, out_alb, out_err, out_timeout},
              {23'd0, 9'b01_01_000_0_1});
        @(posedge clk); #1;
        drain("timeout_drain");
`else
        any = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) any = 1'b1;
        end
        check("no_timeout_result", {any, cmp_start}, 32'd1);
        #2 rst = 1'b0;
        model_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
`endif
        no_done = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
